regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor to the core's 32x32 register file.
- Configurable data width, depth and number of read ports.
- Registered reads with optional write-to-read bypass; hardwired-zero entry 0.
- Per-register busy scoreboard so the issue stage can stall on pending writebacks.
- Sits between the decode/issue stage (read and reserve) and the writeback stage (write).

Parameters:
- XLEN, 32, data width of each register in bits.
- DEPTH, 32, number of registers; power of two, >= 2. Local AW = $clog2(DEPTH).
- NUM_RD, 2, number of read ports; 1..4.
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read; 0 = the read returns the pre-write value.
- ZERO_REG, 1, 1 = entry 0 always reads 0, ignores writes and is never busy.

Ports:
- clk, in, 1, clock; all state updates on posedge.
- rst, in, 1, synchronous active-high reset.
- rd_en, in, NUM_RD, per-port read enable.
- rd_addr, in, NUM_RD*AW, flattened read addresses; port i uses bits [i*AW +: AW].
- rd_data, out, NUM_RD*XLEN, flattened registered read data.
- rd_busy, out, NUM_RD, registered busy flag of the addressed register, sampled with rd_data.
- we, in, 1, write enable.
- wr_addr, in, AW, write address.
- wr_data, in, XLEN, write data.
- rsv_en, in, 1, reserve request: marks rsv_addr busy.
- rsv_addr, in, AW, register to reserve.
- busy_vec, out, DEPTH, live scoreboard, bit n = register n busy.

Behaviour:
- Reset (rst=1 at posedge):
  - all registers <= 0, busy_vec <= 0, rd_data <= 0, rd_busy <= 0.
  - rst overrides we, rsv_en and rd_en in the same cycle.
  - Reset mid-operation discards any pending reservations.
- Read, 1-cycle latency, per port i:
  - On a posedge with rd_en[i]=1, rd_data slice i <= value of regs[rd_addr_i].
  - rd_busy[i] <= busy_vec[rd_addr_i], evaluated after the bypass rules below.
  - rd_en[i]=0: rd_data slice i and rd_busy[i] hold their previous values.
  - Ports are independent. Equal addresses on several ports return identical data.
- Bypass, when we=1 and wr_addr==rd_addr_i:
  - BYPASS=1: rd_data slice i <= wr_data and rd_busy[i] <= 0, unless the same register is also being reserved this cycle (see the next rule).
  - BYPASS=0: rd_data slice i <= old register value and rd_busy[i] <= old busy bit.
- Reserve and write in the same cycle:
  - rsv_en=1 and rsv_addr==rd_addr_i: rd_busy[i] <= 1 when BYPASS=1; old busy bit when BYPASS=0.
- Write:
  - we=1 at posedge: regs[wr_addr] <= wr_data and busy_vec[wr_addr] <= 0.
  - Single write port. No write-after-write ordering is needed beyond this.
- Reserve:
  - rsv_en=1 at posedge: busy_vec[rsv_addr] <= 1.
  - Write and reserve to the same address in the same cycle: register takes wr_data and busy ends at 1 (new producer wins).
  - Reserving an already-busy register leaves it busy. No counting; a single write clears it.
- Zero register, ZERO_REG=1:
  - Writes and reserves to address 0 are ignored.
  - Reads of 0 give 0 with busy 0, including when a bypass match to address 0 exists.
  - busy_vec[0] is constant 0.
  - ZERO_REG=0: entry 0 behaves like any other register.
- Out-of-range addresses cannot occur because DEPTH is a power of two.
- Register contents are flop/array storage. No read-during-reset data is guaranteed other than 0.

Test Plan:
- Reset then read: assert rst 1 cycle, read addrs 5 and 31 → both rd_data=0, rd_busy=0, busy_vec=0.
- Write/readback, defaults: write 0xDEADBEEF to r7; next cycle read r7 on port 0 and r7 on port 1 → both 0xDEADBEEF one cycle after rd_en.
- Bypass: same cycle we=1, wr_addr=3, wr_data=0x12345678 and read r3 (old value 0xAA).
  - BYPASS=1 → rd_data=0x12345678, rd_busy=0.
  - BYPASS=0 → rd_data=0xAA.
- Scoreboard:
  - rsv_en r9 → busy_vec[9]=1. Read r9 → rd_busy=1.
  - Write r9=0x55 → busy_vec[9]=0.
  - Write plus reserve r9 in the same cycle → data 0x55, busy_vec[9]=1.
- Zero register: write 0xFFFFFFFF to r0 and rsv_en r0 → read r0 gives 0, busy 0, busy_vec[0]=0. Repeat with ZERO_REG=0 → reads 0xFFFFFFFF, busy 1.
- Hold and reset priority:
  - rd_en=0 after reading 0x11 while r1 changes → output stays 0x11.
  - rst asserted together with we to r2 → r2 reads 0 afterwards and all busy bits clear.
  - Also rerun with XLEN=64, DEPTH=16, NUM_RD=3.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file: NUM_RD registered read ports, one write port,
// optional write-to-read bypass, optional hardwired-zero entry 0 and a
// per-register busy scoreboard (reserve at issue, clear at writeback).

// One read port: picks bypass/zero policy and registers data + busy.
module regfile_param_rdport #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [AW-1:0]   i_addr,
  input  logic [XLEN-1:0] i_reg_val,
  input  logic            i_reg_busy,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data,
  input  logic            i_rsv_en,
  input  logic [AW-1:0]   i_rsv_addr,
  output logic [XLEN-1:0] o_data,
  output logic            o_busy
);
  logic [XLEN-1:0] w_nxt_data;
  logic            w_nxt_busy;
  logic [XLEN-1:0] r_data;
  logic            r_busy;

  // Next read value: stored value, then same-cycle write/reserve, then zero entry.
  always_comb begin
    w_nxt_data = i_reg_val;
    w_nxt_busy = i_reg_busy;
    if (BYPASS != 0) begin
      if (i_we && (i_wr_addr == i_addr)) begin
        w_nxt_data = i_wr_data;
        w_nxt_busy = 1'b0;
      end
      // A reserve in the same cycle means a newer producer is pending.
      if (i_rsv_en && (i_rsv_addr == i_addr))
        w_nxt_busy = 1'b1;
    end
    if ((ZERO_REG != 0) && (i_addr == '0)) begin
      w_nxt_data = '0;
      w_nxt_busy = 1'b0;
    end
  end

  // Output register; holds while the port is not enabled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
      r_busy <= 1'b0;
    end else if (i_en) begin
      r_data <= w_nxt_data;
      r_busy <= w_nxt_busy;
    end
  end

  assign o_data = r_data;
  assign o_busy = r_busy;
endmodule

module regfile_param #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_RD-1:0]      i_rd_en,
  input  logic [NUM_RD*AW-1:0]   i_rd_addr,
  output logic [NUM_RD*XLEN-1:0] o_rd_data,
  output logic [NUM_RD-1:0]      o_rd_busy,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [XLEN-1:0]        i_wr_data,
  input  logic                   i_rsv_en,
  input  logic [AW-1:0]          i_rsv_addr,
  output logic [DEPTH-1:0]       o_busy_vec
);
  logic [DEPTH-1:0][XLEN-1:0]  r_regs;
  logic [DEPTH-1:0]            r_busy;
  logic [DEPTH-1:0]            w_busy;
  logic [NUM_RD-1:0][AW-1:0]   w_rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0] w_rd_data;
  logic                        w_wr_ok;
  logic                        w_rsv_ok;

  // Writes and reserves aimed at a hardwired-zero entry are dropped here.
  assign w_wr_ok  = i_we     && !((ZERO_REG != 0) && (i_wr_addr  == '0));
  assign w_rsv_ok = i_rsv_en && !((ZERO_REG != 0) && (i_rsv_addr == '0));

  // Register storage, single write port.
  always_ff @(posedge i_clk) begin
    if (i_rst)        r_regs <= '0;
    else if (w_wr_ok) r_regs[i_wr_addr] <= i_wr_data;
  end

  // Scoreboard: write clears, reserve sets; reserve is last so it wins a tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      if (w_wr_ok)  r_busy[i_wr_addr]  <= 1'b0;
      if (w_rsv_ok) r_busy[i_rsv_addr] <= 1'b1;
    end
  end

  // Bit 0 is tied off outright when entry 0 is hardwired.
  assign w_busy     = (ZERO_REG != 0) ? {r_busy[DEPTH-1:1], 1'b0} : r_busy;
  assign o_busy_vec = w_busy;
  assign w_rd_addr  = i_rd_addr;
  assign o_rd_data  = w_rd_data;

  genvar g;
  generate
    for (g = 0; g < NUM_RD; g++) begin : g_rd
      regfile_param_rdport #(
        .XLEN(XLEN), .AW(AW), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
      ) u_rd (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_rd_en[g]),
        .i_addr     (w_rd_addr[g]),
        .i_reg_val  (r_regs[w_rd_addr[g]]),
        .i_reg_busy (w_busy[w_rd_addr[g]]),
        .i_we       (w_wr_ok),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .i_rsv_en   (w_rsv_ok),
        .i_rsv_addr (i_rsv_addr),
        .o_data     (w_rd_data[g]),
        .o_busy     (o_rd_busy[g])
      );
    end
  endgenerate
endmodule

// File: tb/tb_regfile_param.sv
// Directed bench: default config (a), BYPASS=0/ZERO_REG=0 (b) sharing stimulus,
// and a 64-bit, 16-deep, 3-read-port config (c).
module tb_regfile_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // shared stimulus for a/b
  logic        rst, we, rsv_en;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [4:0]  wr_addr, rsv_addr;
  logic [31:0] wr_data;
  logic [63:0] a_rd, b_rd;
  logic [1:0]  a_rb, b_rb;
  logic [31:0] a_bv, b_bv;

  // stimulus for c
  logic         c_rst, c_we, c_rsv_en;
  logic [2:0]   c_rd_en;
  logic [11:0]  c_rd_addr;
  logic [3:0]   c_wr_addr, c_rsv_addr;
  logic [63:0]  c_wr_data;
  logic [191:0] c_rd;
  logic [2:0]   c_rb;
  logic [15:0]  c_bv;

  regfile_param u_a (
    .i_clk(clk), .i_rst(rst), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(a_rd), .o_rd_busy(a_rb), .i_we(we), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_busy_vec(a_bv)
  );

  regfile_param #(.BYPASS(0), .ZERO_REG(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(b_rd), .o_rd_busy(b_rb), .i_we(we), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_busy_vec(b_bv)
  );

  regfile_param #(.XLEN(64), .DEPTH(16), .NUM_RD(3)) u_c (
    .i_clk(clk), .i_rst(c_rst), .i_rd_en(c_rd_en), .i_rd_addr(c_rd_addr),
    .o_rd_data(c_rd), .o_rd_busy(c_rb), .i_we(c_we), .i_wr_addr(c_wr_addr),
    .i_wr_data(c_wr_data), .i_rsv_en(c_rsv_en), .i_rsv_addr(c_rsv_addr), .o_busy_vec(c_bv)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one edge, sample 1 time unit later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; rsv_en = 1'b0; rd_en = 2'b00;
    c_rst = 1'b0; c_we = 1'b0; c_rsv_en = 1'b0; c_rd_en = 3'b000;
  endtask

  initial begin
    idle();
    rd_addr = '0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
    c_rd_addr = '0; c_wr_addr = '0; c_rsv_addr = '0; c_wr_data = '0;

    // reset overrides a write, a reserve and reads in the same cycle
    rst = 1'b1; c_rst = 1'b1; rd_en = 2'b11; rd_addr = {5'd31, 5'd5};
    we = 1'b1; wr_addr = 5'd2; wr_data = 32'h99; rsv_en = 1'b1; rsv_addr = 5'd4;
    cyc();
    chk("rst_a_data", a_rd, 64'h0);
    chk("rst_a_busy", a_rb, 2'b00);
    chk("rst_a_bv",   a_bv, 32'h0);
    chk("rst_b_bv",   b_bv, 32'h0);
    chk("rst_c_bv",   c_bv, 16'h0);

    // read r5 / r31 after reset
    idle(); rd_en = 2'b11; rd_addr = {5'd31, 5'd5};
    cyc();
    chk("post_rst_a_data", a_rd, 64'h0);
    chk("post_rst_b_data", b_rd, 64'h0);
    chk("post_rst_b_busy", b_rb, 2'b00);

    // write r7, then read it on both ports
    idle(); we = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
    cyc();
    idle(); rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
    cyc();
    chk("wr7_a", a_rd, 64'hDEADBEEF_DEADBEEF);
    chk("wr7_b", b_rd, 64'hDEADBEEF_DEADBEEF);

    // r3 = 0xAA, then write 0x12345678 while reading r3
    idle(); we = 1'b1; wr_addr = 5'd3; wr_data = 32'hAA;
    cyc();
    idle(); we = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678;
    rd_en = 2'b11; rd_addr = {5'd7, 5'd3};
    cyc();
    chk("byp_a_data", a_rd, 64'hDEADBEEF_12345678);
    chk("byp_a_busy", a_rb, 2'b00);
    chk("nobyp_b_data", b_rd, 64'hDEADBEEF_000000AA);

    // read r3 again and reserve r9
    idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd3}; rsv_en = 1'b1; rsv_addr = 5'd9;
    cyc();
    chk("r3_b_data", b_rd[31:0], 32'h12345678);
    chk("rsv9_a_bv", a_bv, 32'h200);
    chk("rsv9_b_bv", b_bv, 32'h200);

    // read busy r9 on port 0, r3 on port 1
    idle(); rd_en = 2'b11; rd_addr = {5'd3, 5'd9};
    cyc();
    chk("rb9_a", a_rb, 2'b01);
    chk("rb9_b", b_rb, 2'b01);

    // writeback r9 = 0x55 while reading it
    idle(); we = 1'b1; wr_addr = 5'd9; wr_data = 32'h55; rd_en = 2'b01; rd_addr = {5'd3, 5'd9};
    cyc();
    chk("wb9_a_data", a_rd[31:0], 32'h55);
    chk("wb9_a_busy", a_rb[0], 1'b0);
    chk("wb9_b_data", b_rd[31:0], 32'h0);
    chk("wb9_b_busy", b_rb[0], 1'b1);
    chk("wb9_a_bv", a_bv, 32'h0);
    chk("wb9_b_bv", b_bv, 32'h0);

    // write + reserve r9 in one cycle while reading it
    idle(); we = 1'b1; wr_addr = 5'd9; wr_data = 32'h77; rsv_en = 1'b1; rsv_addr = 5'd9;
    rd_en = 2'b01; rd_addr = {5'd3, 5'd9};
    cyc();
    chk("wrsv9_a_data", a_rd[31:0], 32'h77);
    chk("wrsv9_a_busy", a_rb[0], 1'b1);
    chk("wrsv9_b_data", b_rd[31:0], 32'h55);
    chk("wrsv9_b_busy", b_rb[0], 1'b0);
    chk("wrsv9_a_bv", a_bv, 32'h200);
    chk("wrsv9_b_bv", b_bv, 32'h200);

    idle(); rd_en = 2'b01; rd_addr = {5'd3, 5'd9};
    cyc();
    chk("rd9_a", {a_rb[0], a_rd[31:0]}, {1'b1, 32'h77});
    chk("rd9_b", {b_rb[0], b_rd[31:0]}, {1'b1, 32'h77});

    // zero register: write and reserve r0
    idle(); we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rsv_en = 1'b1; rsv_addr = 5'd0;
    cyc();
    chk("z_a_bv", a_bv, 32'h200);
    chk("z_b_bv", b_bv, 32'h201);
    idle(); rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
    cyc();
    chk("z_a_data", a_rd, 64'h0);
    chk("z_a_busy", a_rb, 2'b00);
    chk("z_b_data", b_rd, 64'hFFFFFFFF_FFFFFFFF);
    chk("z_b_busy", b_rb, 2'b11);

    // bypass match on r0
    idle(); we = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rd_en = 2'b01; rd_addr = {5'd0, 5'd0};
    cyc();
    chk("zbyp_a", {a_rb[0], a_rd[31:0]}, {1'b0, 32'h0});
    chk("zbyp_b", {b_rb[0], b_rd[31:0]}, {1'b1, 32'hFFFFFFFF});
    chk("zbyp_b_bv", b_bv, 32'h200);

    // hold: read r1 = 0x11, then change r1 with rd_en low
    idle(); we = 1'b1; wr_addr = 5'd1; wr_data = 32'h11;
    cyc();
    idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd1};
    cyc();
    chk("r1_a", a_rd[31:0], 32'h11);
    idle(); we = 1'b1; wr_addr = 5'd1; wr_data = 32'h22;
    cyc();
    chk("hold_a", a_rd[31:0], 32'h11);
    chk("hold_b", b_rd[31:0], 32'h11);
    idle();
    cyc();
    chk("hold2_a", a_rd[31:0], 32'h11);

    // pending reservations, then reset with a write to r2
    idle(); rsv_en = 1'b1; rsv_addr = 5'd2;
    cyc();
    idle(); rsv_en = 1'b1; rsv_addr = 5'd5;
    cyc();
    chk("prersv_a_bv", a_bv, 32'h224);
    chk("prersv_b_bv", b_bv, 32'h224);
    idle(); rst = 1'b1; we = 1'b1; wr_addr = 5'd2; wr_data = 32'h99;
    rsv_en = 1'b1; rsv_addr = 5'd6; rd_en = 2'b11; rd_addr = {5'd9, 5'd9};
    cyc();
    chk("rst2_a_bv", a_bv, 32'h0);
    chk("rst2_b_bv", b_bv, 32'h0);
    chk("rst2_a_out", {a_rb, a_rd}, 66'h0);
    idle(); rd_en = 2'b11; rd_addr = {5'd5, 5'd2};
    cyc();
    chk("rst2_a_rd", {a_rb, a_rd}, 66'h0);
    chk("rst2_b_rd", {b_rb, b_rd}, 66'h0);

    // wide config: 64-bit, 16 deep, 3 read ports
    idle(); c_we = 1'b1; c_wr_addr = 4'd15; c_wr_data = 64'h01234567_89ABCDEF;
    cyc();
    idle(); c_rsv_en = 1'b1; c_rsv_addr = 4'd4;
    cyc();
    chk("c_rsv_bv", c_bv, 16'h0010);
    idle(); c_we = 1'b1; c_wr_addr = 4'd4; c_wr_data = 64'hFEDCBA98_76543210;
    c_rd_en = 3'b111; c_rd_addr = {4'd0, 4'd15, 4'd4};
    cyc();
    chk("c_p0", c_rd[63:0],    64'hFEDCBA98_76543210);
    chk("c_p1", c_rd[127:64],  64'h01234567_89ABCDEF);
    chk("c_p2", c_rd[191:128], 64'h0);
    chk("c_busy", c_rb, 3'b000);
    chk("c_bv", c_bv, 16'h0);
    idle(); c_rsv_en = 1'b1; c_rsv_addr = 4'd4; c_rd_en = 3'b001; c_rd_addr = {4'd0, 4'd15, 4'd4};
    cyc();
    chk("c_rsvbyp", {c_rb, c_rd[63:0]}, {3'b001, 64'hFEDCBA98_76543210});
    chk("c_hold_p1", c_rd[127:64], 64'h01234567_89ABCDEF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
